// File: rtl/rbfu_net_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rbfu_net_sched_pkg
// Brief    : Shared constants, FSM encoding and lane-select helper for the
//            RBFU permutation-network sequencer.
// Revision : 1.0
// ============================================================================
package rbfu_net_sched_pkg;

    localparam int P             = 4;
    localparam int N_LANES       = 2 * P;
    localparam int MAP           = 3;
    localparam int L             = 4;
    localparam int DRAIN_LAT     = L + 1;
    localparam int STAGES        = 8;
    localparam int CYC_PER_STAGE = 32;

    localparam int STAGE_W = $clog2(STAGES);
    localparam int CYC_W   = $clog2(CYC_PER_STAGE);
    localparam int CNT_W   = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
    localparam int SEL_W   = MAP * N_LANES;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Rotation by (cyc + stage); wraps naturally because N_LANES == 2**MAP.
    function automatic logic [MAP-1:0] lane_sel(
        input int                 lane,
        input logic [CYC_W-1:0]   cyc,
        input logic [STAGE_W-1:0] stage
    );
        return MAP'(lane) + MAP'(cyc) + MAP'(stage);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rbfu_net_sched_shift.sv
`default_nettype none
// ============================================================================
// Module   : rbfu_net_sched_shift
// Brief    : Fixed-depth delay line with asynchronous clear.
// Revision : 1.0
// ============================================================================
module rbfu_net_sched_shift #(
    parameter int SHIFT      = 5,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_pipe [SHIFT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SHIFT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_din;
            for (int i = 1; i < SHIFT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_dout = r_pipe[SHIFT-1];

endmodule

`default_nettype wire

// File: rtl/rbfu_net_sched.sv
`default_nettype none
// ============================================================================
// Module   : rbfu_net_sched
// Brief    : Per-cycle lane-select / issue sequencer for one NTT pass, with
//            inter-stage drain bubbles and a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module rbfu_net_sched
    import rbfu_net_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_stall,
    output logic [SEL_W-1:0]   o_sel_BI_bus,
    output logic               o_issue_vld,
    output logic [STAGE_W-1:0] o_stage_idx,
    output logic [CYC_W-1:0]   o_cyc_idx,
    output logic               o_wb_vld,
    output logic               o_busy,
    output logic               o_done
);

    if ((1 << MAP) != N_LANES) begin : g_bad_lane_count
        $error("rbfu_net_sched: N_LANES must equal 2**MAP");
    end

    state_t             r_state;
    logic [STAGE_W-1:0] r_stage;
    logic [CYC_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_issue_vld;
    logic               r_busy;
    logic               r_done;

    logic               w_cyc_last;
    logic               w_stage_last;
    logic               w_cnt_last;
    logic               w_load_sel;
    logic [STAGE_W-1:0] w_nxt_stage;
    logic [CYC_W-1:0]   w_nxt_cyc;

    assign w_cyc_last   = (r_cyc   == CYC_W'(CYC_PER_STAGE - 1));
    assign w_stage_last = (r_stage == STAGE_W'(STAGES - 1));
    assign w_cnt_last   = (r_cnt   == CNT_W'(DRAIN_LAT - 1));

    // Indices of the next issue slot; selects reload only when one is coming.
    always_comb begin
        w_load_sel  = 1'b0;
        w_nxt_stage = r_stage;
        w_nxt_cyc   = r_cyc;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load_sel  = 1'b1;
                    w_nxt_stage = '0;
                    w_nxt_cyc   = '0;
                end
            end
            S_RUN: begin
                if (r_issue_vld && !w_cyc_last) begin
                    w_load_sel = 1'b1;
                    w_nxt_cyc  = r_cyc + CYC_W'(1);
                end
            end
            S_GAP: begin
                if (w_cnt_last) begin
                    w_load_sel  = 1'b1;
                    w_nxt_stage = r_stage + STAGE_W'(1);
                    w_nxt_cyc   = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Stall is sampled at the edge, so it gates the issue slot that follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_stage     <= '0;
            r_cyc       <= '0;
            r_cnt       <= '0;
            r_issue_vld <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_RUN;
                        r_stage     <= '0;
                        r_cyc       <= '0;
                        r_issue_vld <= !i_stall;
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_issue_vld && w_cyc_last) begin
                        r_cyc       <= '0;
                        r_cnt       <= '0;
                        r_issue_vld <= 1'b0;
                        r_state     <= w_stage_last ? S_DRAIN : S_GAP;
                    end else begin
                        if (r_issue_vld) begin
                            r_cyc <= r_cyc + CYC_W'(1);
                        end
                        r_issue_vld <= !i_stall;
                    end
                end
                S_GAP: begin
                    if (w_cnt_last) begin
                        r_state     <= S_RUN;
                        r_stage     <= r_stage + STAGE_W'(1);
                        r_issue_vld <= !i_stall;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_cnt_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        logic [MAP-1:0] r_sel;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sel <= '0;
            end else if (w_load_sel) begin
                r_sel <= lane_sel(gi, w_nxt_cyc, w_nxt_stage);
            end
        end

        assign o_sel_BI_bus[gi*MAP +: MAP] = r_sel;
    end

    rbfu_net_sched_shift #(
        .SHIFT      (DRAIN_LAT),
        .DATA_WIDTH (1)
    ) u_wb_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (r_issue_vld),
        .o_dout (o_wb_vld)
    );

    assign o_issue_vld = r_issue_vld;
    assign o_stage_idx = r_stage;
    assign o_cyc_idx   = r_cyc;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rbfu_net_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbfu_net_sched
// Brief    : Directed self-checking bench for rbfu_net_sched.
// Revision : 1.0
// ============================================================================
module tb_rbfu_net_sched;
    import rbfu_net_sched_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_start;
    logic               i_stall;
    logic [SEL_W-1:0]   o_sel_BI_bus;
    logic               o_issue_vld;
    logic [STAGE_W-1:0] o_stage_idx;
    logic [CYC_W-1:0]   o_cyc_idx;
    logic               o_wb_vld;
    logic               o_busy;
    logic               o_done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rbfu_net_sched u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_stall      (i_stall),
        .o_sel_BI_bus (o_sel_BI_bus),
        .o_issue_vld  (o_issue_vld),
        .o_stage_idx  (o_stage_idx),
        .o_cyc_idx    (o_cyc_idx),
        .o_wb_vld     (o_wb_vld),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic test_reset();
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_stall = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({o_sel_BI_bus, o_issue_vld, o_stage_idx, o_cyc_idx, o_wb_vld, o_busy, o_done} !== '0) begin
            $display("FAIL reset_outputs: got sel=%o vld=%b stg=%0d cyc=%0d wb=%b busy=%b done=%b, want all 0",
                     o_sel_BI_bus, o_issue_vld, o_stage_idx, o_cyc_idx, o_wb_vld, o_busy, o_done);
        end else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({o_busy, o_issue_vld} !== 2'b00) begin
            $display("FAIL idle_no_start: got busy=%b vld=%b, want 0 0", o_busy, o_issue_vld);
        end else n_pass++;
    endtask

    task automatic test_nominal();
        int c, issues, wbs, last_wb, gaps, gap_len, bad_gap, busy_low, done_cyc;
        bit sel_mid_seen, sel_end_seen;
        issues = 0; wbs = 0; last_wb = -1; gaps = 0; gap_len = 0; bad_gap = 0;
        busy_low = 0; done_cyc = -1; sel_mid_seen = 0; sel_end_seen = 0;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        c = 1;
        n_total++;
        if ({o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus} !== {1'b1, 3'd0, 5'd0, 24'o76543210}) begin
            $display("FAIL first_issue: got vld=%b stg=%0d cyc=%0d sel=%o, want 1 0 0 76543210",
                     o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus);
        end else n_pass++;
        while (c <= 400) begin
            if (o_issue_vld) begin
                issues++;
                if (gap_len > 0) begin
                    gaps++;
                    if (gap_len != 5) bad_gap++;
                    gap_len = 0;
                end
            end else if (issues > 0) begin
                gap_len++;
            end
            if (o_wb_vld) begin
                wbs++;
                last_wb = c;
            end
            if (o_issue_vld && o_stage_idx == 3'd2 && o_cyc_idx == 5'd7) begin
                sel_mid_seen = 1;
                n_total++;
                if (o_sel_BI_bus !== 24'o07654321)
                    $display("FAIL sel_s2_c7: got %o, want 07654321", o_sel_BI_bus);
                else n_pass++;
            end
            if (o_issue_vld && o_stage_idx == 3'd7 && o_cyc_idx == 5'd31) begin
                sel_end_seen = 1;
                n_total++;
                if (o_sel_BI_bus !== 24'o54321076)
                    $display("FAIL sel_s7_c31: got %o, want 54321076", o_sel_BI_bus);
                else n_pass++;
            end
            if (!o_busy) busy_low++;
            if (o_done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        n_total++;
        if (done_cyc !== 297) $display("FAIL nom_done_cycle: got %0d, want 297", done_cyc);
        else n_pass++;
        n_total++;
        if (issues !== 256) $display("FAIL nom_issue_count: got %0d, want 256", issues);
        else n_pass++;
        n_total++;
        if ({gaps, bad_gap} !== {32'd7, 32'd0})
            $display("FAIL nom_gaps: got %0d gaps (%0d wrong length), want 7 gaps of 5", gaps, bad_gap);
        else n_pass++;
        n_total++;
        if ({wbs, last_wb} !== {32'd256, 32'd296})
            $display("FAIL nom_wb: got count=%0d last=%0d, want 256 296", wbs, last_wb);
        else n_pass++;
        n_total++;
        if (busy_low !== 0) $display("FAIL nom_busy: got %0d low cycles, want 0", busy_low);
        else n_pass++;
        n_total++;
        if ({sel_mid_seen, sel_end_seen} !== 2'b11)
            $display("FAIL nom_sel_reached: got %b%b, want 11", sel_mid_seen, sel_end_seen);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({o_done, o_busy} !== 2'b00)
            $display("FAIL nom_after_done: got done=%b busy=%b, want 0 0", o_done, o_busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        int c, done_cyc;
        logic [4:0] wb_pat;
        done_cyc = -1;
        wb_pat = '0;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        c = 1;
        while (!(o_issue_vld && o_cyc_idx == 5'd4) && c < 20) begin
            @(negedge clk);
            c++;
        end
        n_total++;
        if (c !== 5) $display("FAIL stall_reach_cyc4: got cycle %0d, want 5", c);
        else n_pass++;
        i_stall = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            c++;
            n_total++;
            if ({o_issue_vld, o_cyc_idx, o_stage_idx} !== {1'b0, 5'd5, 3'd0})
                $display("FAIL stall_hold_%0d: got vld=%b cyc=%0d stg=%0d, want 0 5 0",
                         j, o_issue_vld, o_cyc_idx, o_stage_idx);
            else n_pass++;
        end
        i_stall = 1'b0;
        @(negedge clk);
        c++;
        n_total++;
        if ({o_issue_vld, o_cyc_idx} !== {1'b1, 5'd5})
            $display("FAIL stall_resume: got vld=%b cyc=%0d, want 1 5", o_issue_vld, o_cyc_idx);
        else n_pass++;
        while (c <= 420) begin
            if (c >= 10 && c <= 14) wb_pat[c-10] = o_wb_vld;
            if (o_done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        n_total++;
        if (wb_pat !== 5'b10001) $display("FAIL stall_wb_hole: got %b (c14..c10), want 10001", wb_pat);
        else n_pass++;
        n_total++;
        if (done_cyc !== 300) $display("FAIL stall_done_cycle: got %0d, want 300", done_cyc);
        else n_pass++;
    endtask

    task automatic test_gap_stall();
        int c, done_cyc;
        done_cyc = -1;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        c = 1;
        while (c < 32) begin
            @(negedge clk);
            c++;
        end
        n_total++;
        if ({o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus} !== {1'b1, 3'd0, 5'd31, 24'o65432107})
            $display("FAIL gap_last_issue: got vld=%b stg=%0d cyc=%0d sel=%o, want 1 0 31 65432107",
                     o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus);
        else n_pass++;
        for (int j = 33; j <= 37; j++) begin
            @(negedge clk);
            c++;
            n_total++;
            if ({o_issue_vld, o_stage_idx, o_sel_BI_bus} !== {1'b0, 3'd0, 24'o65432107})
                $display("FAIL gap_cycle_%0d: got vld=%b stg=%0d sel=%o, want 0 0 65432107",
                         j, o_issue_vld, o_stage_idx, o_sel_BI_bus);
            else n_pass++;
            if (j == 33) i_stall = 1'b1;
            if (j == 35) i_stall = 1'b0;
        end
        @(negedge clk);
        c++;
        n_total++;
        if ({o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus} !== {1'b1, 3'd1, 5'd0, 24'o07654321})
            $display("FAIL gap_stage1_start: got vld=%b stg=%0d cyc=%0d sel=%o, want 1 1 0 07654321",
                     o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus);
        else n_pass++;
        while (c <= 400) begin
            if (o_done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        n_total++;
        if (done_cyc !== 297) $display("FAIL gap_done_cycle: got %0d, want 297", done_cyc);
        else n_pass++;
    endtask

    task automatic test_start_handling();
        int c, done_cnt, done_cyc;
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        c = 1;
        while (1) begin
            if (c == 10) i_start = 1'b1;
            if (c == 11) i_start = 1'b0;
            if (o_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == 297) break;
            @(negedge clk);
            c++;
        end
        n_total++;
        if ({done_cnt, done_cyc} !== {32'd1, 32'd297})
            $display("FAIL start_ignored_run: got %0d pulses, last at %0d, want 1 at 297", done_cnt, done_cyc);
        else n_pass++;
        i_start = 1'b1;
        @(negedge clk);
        n_total++;
        if ({o_busy, o_done, o_issue_vld} !== 3'b000)
            $display("FAIL start_in_done: got busy=%b done=%b vld=%b, want 0 0 0", o_busy, o_done, o_issue_vld);
        else n_pass++;
        @(negedge clk);
        i_start = 1'b0;
        n_total++;
        if ({o_busy, o_issue_vld, o_stage_idx, o_cyc_idx} !== {1'b1, 1'b1, 3'd0, 5'd0})
            $display("FAIL start_after_done: got busy=%b vld=%b stg=%0d cyc=%0d, want 1 1 0 0",
                     o_busy, o_issue_vld, o_stage_idx, o_cyc_idx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int c;
        logic [5:0] wb_seq;
        c = 1;
        wb_seq = '0;
        while (!(o_issue_vld && o_stage_idx == 3'd3 && o_cyc_idx == 5'd10) && c < 200) begin
            @(negedge clk);
            c++;
        end
        n_total++;
        if (c !== 122) $display("FAIL rst_reach_s3c10: got cycle %0d, want 122", c);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_sel_BI_bus, o_issue_vld, o_stage_idx, o_cyc_idx, o_wb_vld, o_busy, o_done} !== '0)
            $display("FAIL rst_async: got sel=%o vld=%b stg=%0d cyc=%0d wb=%b busy=%b done=%b, want all 0",
                     o_sel_BI_bus, o_issue_vld, o_stage_idx, o_cyc_idx, o_wb_vld, o_busy, o_done);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        n_total++;
        if ({o_busy, o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus} !== {1'b1, 1'b1, 3'd0, 5'd0, 24'o76543210})
            $display("FAIL rst_restart: got busy=%b vld=%b stg=%0d cyc=%0d sel=%o, want 1 1 0 0 76543210",
                     o_busy, o_issue_vld, o_stage_idx, o_cyc_idx, o_sel_BI_bus);
        else n_pass++;
        for (int j = 0; j < 6; j++) begin
            wb_seq[j] = o_wb_vld;
            @(negedge clk);
        end
        n_total++;
        if (wb_seq !== 6'b100000) $display("FAIL rst_wb_cleared: got %b (c6..c1), want 100000", wb_seq);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_gap_stall();
        test_start_handling();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rbfu_net_sched.md
Name: rbfu_net_sched

Overview:
- Sequencer for the RBFU input/output permutation networks during one multi-stage NTT pass.
- Per cycle it emits the packed lane-select vector (`MAP bits per lane, 2*`P lanes), a butterfly-issue valid, and stage/cycle indices.
- Inserts inter-stage bubbles so stage s+1 never issues before stage s results have drained through the `L+1-deep RBFU/output-network pipeline.
- Provides start/busy/done handshake toward the top-level NTT controller.

Parameters:
- P, `P (4), butterfly units; lanes N_LANES = 2*P.
- MAP, `MAP (3), select width per lane = log2(N_LANES).
- L, `L (4), RBFU pipeline depth; drain latency = L+1.
- STAGES, 8, NTT stages per pass.
- CYC_PER_STAGE, 32, issue cycles per stage (NPOINT/(2P)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pass request; honoured only in IDLE.
- stall  in  1  memory not ready; freezes issue while high.
- sel_BI_bus  out  MAP*2P  packed lane selects, lane i at [i*MAP +: MAP].
- issue_vld  out  1  butterflies issued this cycle.
- stage_idx  out  clog2(STAGES)  current stage.
- cyc_idx  out  clog2(CYC_PER_STAGE)  issue cycle within stage.
- wb_vld  out  1  issue_vld delayed L+1 cycles; aligns with network output.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at pass completion.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; sel_BI_bus, stage_idx, cyc_idx, issue_vld, done = 0; wb_vld delay line cleared; busy=0.
- FSM states IDLE, RUN, GAP, DRAIN, DONE.
- IDLE: start=1 → RUN next cycle with stage=0, cyc=0.
- RUN, stall=0: issue_vld=1; sel lane i = (i + cyc + stage) mod N_LANES (MAP-bit wrap).
  - cyc increments each issue cycle.
  - At cyc = CYC_PER_STAGE-1: cyc→0.
  - If stage < STAGES-1: go to GAP and stage+1 is loaded on GAP exit.
  - Else: go to DRAIN.
- RUN, stall=1: issue_vld=0; indices and sel held; no state change.
- GAP: gap counter runs L+1 cycles, issue_vld=0, sel held.
  - Counter expires → RUN with stage+1, cyc=0.
  - stall does not extend GAP.
- DRAIN: L+1 cycles, issue_vld=0, then DONE.
- DONE: done=1 for exactly one cycle → IDLE. busy drops in the same cycle IDLE is entered.
- start while busy: ignored, no queuing.
- start in the cycle DONE→IDLE: ignored; next start is accepted the following cycle.
- Outputs are registered. First issue_vld is 1 cycle after start is sampled.
- wb_vld is a pure L+1 shift of issue_vld, including stall holes.
- Last wb_vld=1 falls in the final DRAIN cycle; done follows 1 cycle later.
- Latency with no stall: STAGES*CYC_PER_STAGE + (STAGES-1)*(L+1) + (L+1) cycles from first issue to the cycle before done.
- Index arithmetic is unsigned. sel addition is truncated to MAP bits, which requires N_LANES to be a power of 2 (elaboration check).

Decomposition:
- Shared package/defines (parameter.v): `P, `MAP, `L, STAGES, CYC_PER_STAGE, FSM state encoding constants.
- One sub-module: reuse existing shift (SHIFT=L+1, data_width=1) for the wb_vld delay line.
- Select generation is an inline generate loop; no separate module.

Test Plan:
- Reset mid-RUN (stage=3, cyc=10): drop rst → all outputs 0 immediately, FSM IDLE; next start restarts at stage 0, cyc 0.
- Nominal pass, defaults, no stall:
  - start at t0 → issue_vld first high t0+1.
  - 256 issue cycles total.
  - 7 gaps of 5 cycles each.
  - done at t0+1+256+35+5 = t0+297.
  - busy high throughout.
- Select pattern: stage=2, cyc=7 → lane i sel = (i+9) mod 8, i.e. lane0=1, lane7=0, packed sel_BI_bus=24'o07654321 (MSB lane7 first).
- Stall: stall high 3 cycles at stage 0, cyc 5.
  - cyc_idx holds 5, issue_vld=0 for those cycles.
  - wb_vld shows a 3-cycle hole exactly 5 cycles later.
  - done delayed by 3.
- Stall during GAP: 2-cycle stall inside gap → GAP still 5 cycles, stage 1 starts on schedule.
- start handling:
  - start asserted during RUN and in the DONE cycle → ignored, exactly one done pulse.
  - start one cycle after done → new pass accepted.
